// File: rtl/sw_test_status_pkg.sv
// Shared status codes, per-channel state encoding and helpers for the
// multi-channel software test-status monitor.
package sw_test_status_pkg;

  typedef enum logic [15:0] {
    UnderReset = 16'h016f,
    InBootRom  = 16'hb090,
    InTest     = 16'h4354,
    InWfi      = 16'h1d1e,
    Passed     = 16'h900d,
    Failed     = 16'hbaad
  } sw_test_status_e;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_BOOT    = 3'd1,
    ST_TEST    = 3'd2,
    ST_WFI     = 3'd3,
    ST_PASSED  = 3'd4,
    ST_FAILED  = 3'd5,
    ST_TIMEOUT = 3'd6
  } ch_state_e;

  function automatic logic is_terminal(input ch_state_e s);
    return (s == ST_PASSED) || (s == ST_FAILED) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/sw_test_status_ch.sv
// One status channel: status word, progress FSM, stall counter and sticky
// error flag. Terminal states freeze everything until reset.
module sw_test_status_ch
  import sw_test_status_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] status_o,
  output logic [2:0]       state_o,
  output logic             err_o,
  output logic             terminal_o,
  output logic             passed_o,
  output logic             failed_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  ch_state_e        state_q, state_d, nxt;
  logic [WIDTH-1:0] status_q, status_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             legal;
  logic             upper_zero;
  logic [15:0]      code;

  assign code       = wr_data_i[15:0];
  // A word with any bit set above the code field is never a valid code.
  assign upper_zero = ((wr_data_i >> 16) == '0);

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    nxt      = state_q;
    legal    = 1'b0;
    if (!is_terminal(state_q)) begin
      if (wr_valid_i) begin
        status_d = wr_data_i;
        if (upper_zero) begin
          case (code)
            Failed:     begin nxt = ST_FAILED; legal = 1'b1; end
            UnderReset: begin nxt = ST_RESET;  legal = 1'b1; end
            InBootRom: if (state_q == ST_RESET) begin
              nxt = ST_BOOT; legal = 1'b1;
            end
            InTest: if (state_q == ST_BOOT || state_q == ST_WFI) begin
              nxt = ST_TEST; legal = 1'b1;
            end
            InWfi: if (state_q == ST_TEST) begin
              nxt = ST_WFI; legal = 1'b1;
            end
            Passed: if (state_q == ST_TEST || state_q == ST_WFI) begin
              nxt = ST_PASSED; legal = 1'b1;
            end
            default: ;
          endcase
        end
        if (legal) state_d = nxt;
        else       err_d   = 1'b1;
        if (state_q == ST_TEST || state_d == ST_TEST) cnt_d = '0;
      end else if (state_q == ST_TEST) begin
        if (cnt_q == CNT_LAST) state_d = ST_TIMEOUT;
        if (cnt_q != CNT_MAX)  cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RESET;
      status_q <= WIDTH'(UnderReset);
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign status_o   = status_q;
  assign state_o    = state_q;
  assign err_o      = err_q;
  assign terminal_o = is_terminal(state_q);
  assign passed_o   = (state_q == ST_PASSED);
  assign failed_o   = (state_q == ST_FAILED) || (state_q == ST_TIMEOUT);

endmodule

// File: rtl/sw_test_status_mon.sv
// Multi-channel software test-status monitor: NUM_CH independent channels
// plus aggregate done/pass/fail flags for the end-of-test logic.
module sw_test_status_mon
  import sw_test_status_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       wr_valid,
  input  logic [NUM_CH*WIDTH-1:0] wr_data,
  output logic [NUM_CH*WIDTH-1:0] status,
  output logic [NUM_CH*3-1:0]     ch_state,
  output logic [NUM_CH-1:0]       ch_err,
  output logic                    all_done,
  output logic                    all_passed,
  output logic                    any_failed
);

  logic [NUM_CH-1:0] term;
  logic [NUM_CH-1:0] pass;
  logic [NUM_CH-1:0] fail;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    sw_test_status_ch #(
      .WIDTH  (WIDTH),
      .TIMEOUT(TIMEOUT)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .wr_valid_i(wr_valid[gi]),
      .wr_data_i (wr_data[gi*WIDTH +: WIDTH]),
      .status_o  (status[gi*WIDTH +: WIDTH]),
      .state_o   (ch_state[gi*3 +: 3]),
      .err_o     (ch_err[gi]),
      .terminal_o(term[gi]),
      .passed_o  (pass[gi]),
      .failed_o  (fail[gi])
    );
  end

  assign all_done   = &term;
  assign all_passed = &pass;
  assign any_failed = |fail;

endmodule

// File: tb/tb_sw_test_status_mon.sv
// Bench for sw_test_status_mon: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level model of each channel.
module tb_sw_test_status_mon;

  localparam int NUM_CH  = 4;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 8;

  localparam logic [31:0] C_RST  = 32'h0000_016f;
  localparam logic [31:0] C_BOOT = 32'h0000_b090;
  localparam logic [31:0] C_TEST = 32'h0000_4354;
  localparam logic [31:0] C_WFI  = 32'h0000_1d1e;
  localparam logic [31:0] C_PASS = 32'h0000_900d;
  localparam logic [31:0] C_FAIL = 32'h0000_baad;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_CH-1:0]       wr_valid = '0;
  logic [NUM_CH*WIDTH-1:0] wr_data = '0;
  logic [NUM_CH*WIDTH-1:0] status;
  logic [NUM_CH*3-1:0]     ch_state;
  logic [NUM_CH-1:0]       ch_err;
  logic                    all_done, all_passed, any_failed;

  sw_test_status_mon #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
    .status(status), .ch_state(ch_state), .ch_err(ch_err),
    .all_done(all_done), .all_passed(all_passed), .any_failed(any_failed)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: state numbers 0..6 (4..6 terminal), last word, sticky error and
  // the cycle stamp of the last TEST activity.
  int          m_state [NUM_CH];
  logic [31:0] m_status[NUM_CH];
  bit          m_err   [NUM_CH];
  int          m_last  [NUM_CH];
  int          cyc = 0;
  bit          started = 0;

  task automatic chk(input string nm, input int ch, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s ch%0d at t=%0t: got %h, expected %h", nm, ch, $time, act, exp);
    end
  endtask

  // Next state for a write, or -1 when the code is not accepted here.
  function automatic int legal_next(input int s, input logic [31:0] d);
    if (d == C_FAIL) return 5;
    if (d == C_RST)  return 0;
    if (d == C_BOOT && s == 0) return 1;
    if (d == C_TEST && (s == 1 || s == 3)) return 2;
    if (d == C_WFI  && s == 2) return 3;
    if (d == C_PASS && (s == 2 || s == 3)) return 4;
    return -1;
  endfunction

  always @(posedge clk) begin
    started = 1;
    cyc++;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rst) begin
        m_state[k] = 0; m_status[k] = C_RST; m_err[k] = 0; m_last[k] = cyc;
      end else if (m_state[k] < 4) begin
        if (wr_valid[k]) begin
          logic [31:0] d;
          int n;
          bit in_test;
          d = wr_data[k*WIDTH +: WIDTH];
          n = legal_next(m_state[k], d);
          in_test = (m_state[k] == 2);
          m_status[k] = d;
          if (n < 0) m_err[k] = 1;
          else m_state[k] = n;
          if (in_test || m_state[k] == 2) m_last[k] = cyc;
        end else if (m_state[k] == 2 && cyc - m_last[k] >= TIMEOUT) begin
          m_state[k] = 6;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      bit e_done, e_pass, e_fail;
      e_done = 1; e_pass = 1; e_fail = 0;
      for (int k = 0; k < NUM_CH; k++) begin
        chk("status", k, status[k*WIDTH +: WIDTH], m_status[k]);
        chk("ch_state", k, {29'd0, ch_state[k*3 +: 3]}, 32'(m_state[k]));
        chk("ch_err", k, {31'd0, ch_err[k]}, {31'd0, m_err[k]});
        if (m_state[k] < 4) e_done = 0;
        if (m_state[k] != 4) e_pass = 0;
        if (m_state[k] == 5 || m_state[k] == 6) e_fail = 1;
      end
      chk("all_done", -1, {31'd0, all_done}, {31'd0, e_done});
      chk("all_passed", -1, {31'd0, all_passed}, {31'd0, e_pass});
      chk("any_failed", -1, {31'd0, any_failed}, {31'd0, e_fail});
    end
  end

  task automatic drive(input logic r, input logic [NUM_CH-1:0] v, input logic [NUM_CH*WIDTH-1:0] d);
    rst = r; wr_valid = v; wr_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic wr1(input int ch, input logic [31:0] w);
    logic [NUM_CH-1:0]       v;
    logic [NUM_CH*WIDTH-1:0] d;
    v = '0; d = '0;
    v[ch] = 1'b1;
    d[ch*WIDTH +: WIDTH] = w;
    drive(1'b0, v, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0);
  endtask

  task automatic chk_reset_values(input string nm);
    for (int k = 0; k < NUM_CH; k++) begin
      chk({nm, "_status"}, k, status[k*WIDTH +: WIDTH], 32'h0000_016f);
      chk({nm, "_state"}, k, {29'd0, ch_state[k*3 +: 3]}, 32'd0);
      chk({nm, "_err"}, k, {31'd0, ch_err[k]}, 32'd0);
    end
    chk({nm, "_aggr"}, -1, {29'd0, all_done, all_passed, any_failed}, 32'd0);
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 9))
      0: return C_RST;
      1, 7: return C_BOOT;
      2, 3, 9: return C_TEST;
      4: return C_WFI;
      5: return C_PASS;
      6: return C_FAIL;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] seq[3];
    seq[0] = C_BOOT; seq[1] = C_TEST; seq[2] = C_PASS;

    drive(1'b1, '0, '0);
    drive(1'b1, '0, '0);
    chk_reset_values("reset");
    $display("reset values checked");

    // Staggered boot/test/pass on every channel.
    idle(1);
    for (int t = 0; t < 6; t++) begin
      logic [NUM_CH-1:0]       v;
      logic [NUM_CH*WIDTH-1:0] d;
      v = '0; d = '0;
      for (int k = 0; k < NUM_CH; k++) begin
        if (t - k >= 0 && t - k < 3) begin
          v[k] = 1'b1;
          d[k*WIDTH +: WIDTH] = seq[t-k];
        end
      end
      drive(1'b0, v, d);
    end
    chk("pass_all_passed", -1, {31'd0, all_passed}, 32'd1);
    chk("pass_all_done", -1, {31'd0, all_done}, 32'd1);
    chk("pass_any_failed", -1, {31'd0, any_failed}, 32'd0);
    $display("staggered pass sequence done");

    // Timeout with no activity after entering TEST.
    drive(1'b1, '0, '0);
    wr1(0, C_BOOT);
    wr1(0, C_TEST);
    idle(TIMEOUT - 1);
    chk("to_before", 0, {29'd0, ch_state[2:0]}, 32'd2);
    idle(1);
    chk("to_state", 0, {29'd0, ch_state[2:0]}, 32'd6);
    chk("to_any_failed", 0, {31'd0, any_failed}, 32'd1);
    $display("timeout after idle TEST checked");

    // A write at cycle 7 restarts the stall count.
    drive(1'b1, '0, '0);
    wr1(0, C_BOOT);
    wr1(0, C_TEST);
    idle(TIMEOUT - 2);
    wr1(0, C_TEST);
    idle(1);
    chk("restart_n8", 0, {29'd0, ch_state[2:0]}, 32'd2);
    idle(TIMEOUT - 2);
    chk("restart_n14", 0, {29'd0, ch_state[2:0]}, 32'd2);
    idle(1);
    chk("restart_n15", 0, {29'd0, ch_state[2:0]}, 32'd6);
    $display("timeout restart checked");

    // Long WFI pause never times out.
    drive(1'b1, '0, '0);
    wr1(1, C_BOOT);
    wr1(1, C_TEST);
    wr1(1, C_WFI);
    idle(2000);
    chk("wfi_hold", 1, {29'd0, ch_state[5:3]}, 32'd3);
    wr1(1, C_TEST);
    wr1(1, C_PASS);
    chk("wfi_pass", 1, {29'd0, ch_state[5:3]}, 32'd4);
    $display("WFI pause checked");

    // Out-of-order and illegal writes.
    drive(1'b1, '0, '0);
    wr1(2, C_BOOT);
    wr1(2, C_PASS);
    chk("ooo_err", 2, {31'd0, ch_err[2]}, 32'd1);
    chk("ooo_state", 2, {29'd0, ch_state[8:6]}, 32'd1);
    wr1(2, 32'hdead_beef);
    chk("ill_status", 2, status[2*WIDTH +: WIDTH], 32'hdead_beef);
    chk("ill_state", 2, {29'd0, ch_state[8:6]}, 32'd1);
    $display("illegal writes checked");

    // Terminal stickiness, then reset with a simultaneous write.
    wr1(3, C_BOOT);
    wr1(3, C_FAIL);
    wr1(3, C_TEST);
    chk("term_state", 3, {29'd0, ch_state[11:9]}, 32'd5);
    chk("term_status", 3, status[3*WIDTH +: WIDTH], 32'h0000_baad);
    drive(1'b1, '1, {NUM_CH{C_BOOT}});
    chk_reset_values("rst_wr");
    $display("terminal stickiness and reset checked");

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic [NUM_CH-1:0]       v;
      logic [NUM_CH*WIDTH-1:0] d;
      for (int k = 0; k < NUM_CH; k++) begin
        v[k] = ($urandom_range(0, 3) == 0);
        d[k*WIDTH +: WIDTH] = rand_word();
      end
      drive($urandom_range(0, 149) == 0, v, d);
    end
    $display("random traffic done");

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sw_test_status_mon.md
# sw_test_status_mon

Multi-channel successor to the single 32-bit software test-status interface. It accepts status-code writes from `NUM_CH` independent software agents (harts or test cores) and holds a per-channel status word. It runs a per-channel progress state machine with a stall timeout and produces aggregate pass, fail and done flags for the top-level test harness. It sits between the status-register write decode and the simulation/emulation end-of-test logic.

## Interface
Parameters:
- `NUM_CH`, 4: number of independent status channels (1..16).
- `WIDTH`, 32: status word width. Must be ≥16; codes occupy bits [15:0], upper bits are zero-extended.
- `TIMEOUT`, 1024: maximum cycles a channel may stay in TEST without a write (≥2).

Ports:
- `clk` input 1: single clock.
- `rst` input 1: reset, synchronous, active-high.
- `wr_valid` input `NUM_CH`: per-channel write strobe.
- `wr_data` input `NUM_CH*WIDTH`: per-channel write data; channel k is `[k*WIDTH +: WIDTH]`.
- `status` output `NUM_CH*WIDTH`: last accepted word per channel.
- `ch_state` output `NUM_CH*3`: per-channel FSM state encoding.
- `ch_err` output `NUM_CH`: sticky illegal/out-of-order code flag.
- `all_done` output 1: every channel is in a terminal state.
- `all_passed` output 1: every channel is in PASSED.
- `any_failed` output 1: at least one channel is in FAILED or TIMEOUT.

## Operation
- Codes (package enum, 16-bit):
  - UnderReset = 16'h016f
  - InBootRom = 16'hb090
  - InTest = 16'h4354
  - InWfi = 16'h1d1e
  - Passed = 16'h900d
  - Failed = 16'hbaad
- Per-channel states: RESET=0, BOOT=1, TEST=2, WFI=3, PASSED=4, FAILED=5, TIMEOUT=6.
- Transitions, only on that channel's `wr_valid`:
  - RESET + InBootRom → BOOT.
  - BOOT + InTest → TEST.
  - TEST + InWfi → WFI.
  - WFI + InTest → TEST.
  - TEST/WFI + Passed → PASSED.
  - Any non-terminal state + Failed → FAILED.
  - Any non-terminal state + UnderReset → RESET.
- Any other code, or a legal code not listed for the current state:
  - sets `ch_err`;
  - leaves the state unchanged;
  - still updates `status`.
- Terminal states (PASSED, FAILED, TIMEOUT) ignore all writes: `status` is frozen and `ch_err` is not set. Only `rst` leaves them.
- Stall counter, per channel, width `$clog2(TIMEOUT+1)`:
  - Cleared on entry to TEST and on any write while in TEST.
  - Increments each cycle in TEST without a write.
  - When the counter reaches `TIMEOUT-1` with no write that cycle, the next state is TIMEOUT.
  - Does not count in WFI, BOOT or RESET.
  - Saturates and never wraps.
- A write and a timeout on the same cycle: the write wins.
- Channels are fully independent. Simultaneous writes on all channels are each processed in the same cycle.
- Aggregates, combinational from the registered states:
  - `all_done` = AND of terminal states.
  - `all_passed` = AND of PASSED.
  - `any_failed` = OR of FAILED/TIMEOUT.

## Timing
- Reset values:
  - `status` = UnderReset (zero-extended) on every channel.
  - `ch_state` = RESET.
  - `ch_err` = 0.
  - Counters = 0.
  - `all_done` = 0, `all_passed` = 0, `any_failed` = 0.
- Write latency: a `wr_valid` at edge N updates `status`, `ch_state` and `ch_err` visibly after edge N. Aggregates follow in the same cycle as `ch_state`.
- Timeout: after the last TEST activity at edge N, TIMEOUT is visible after edge N+TIMEOUT.
- `rst` asserted mid-test overrides all writes on that edge and restores all reset values. A write on the reset cycle is discarded.
- No back-pressure: every write is consumed in one cycle.

## Structure
- Package `sw_test_status_pkg` holds:
  - the `sw_test_status_e` 16-bit enum;
  - the `ch_state_e` 3-bit enum;
  - a function `is_terminal()`.
- Sub-module `sw_test_status_ch` contains one channel's status register, FSM, stall counter and error flag. It is parameterised by `WIDTH` and `TIMEOUT`.
- The top instantiates `NUM_CH` copies of `sw_test_status_ch` in a generate loop and reduces the aggregate flags.

## Test plan
- Normal pass, `NUM_CH`=4: each channel is driven InBootRom → InTest → Passed, staggered by 1 cycle. Required response:
  - `all_passed` = 1 and `all_done` = 1 one cycle after the last Passed;
  - `any_failed` stays 0 throughout.
- Timeout, `TIMEOUT`=8: channel 0 is driven to TEST, then left idle. Required response:
  - channel 0 `ch_state` = 6 exactly 8 cycles later, `any_failed` = 1;
  - a write of InTest at cycle 7 instead keeps the state at TEST and restarts the count.
- WFI pause: channel 1 enters WFI and is held there for 2000 cycles. Required response:
  - no timeout occurs;
  - InTest then Passed gives state 4.
- Illegal and out-of-order writes: Passed is written while in BOOT, then 32'hdead_beef. Required response:
  - `ch_err` = 1;
  - state remains BOOT;
  - `status` = 32'hdeadbeef.
- Terminal stickiness and reset: after Failed, write InTest. Required response:
  - state stays FAILED and `status` stays 16'hbaad;
  - asserting `rst` for 1 cycle with a simultaneous `wr_valid` restores all reset values, with `status` = 32'h0000016f.
